// File: rtl/param_word_gen.sv
// Parameterized burst word source: on start, emits COUNT words START, START+STEP, ...
// over a valid/ready handshake, then pulses done and counts the completed burst.
module param_word_gen #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned START = 1,
  parameter int unsigned STEP  = 2,
  parameter int unsigned COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [7:0]       burst_cnt
);

  localparam int unsigned IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  // START/STEP are taken as 32-bit values; the cast truncates or zero-extends to WIDTH
  localparam logic [31:0]      START32  = START;
  localparam logic [31:0]      STEP32   = STEP;
  localparam logic [WIDTH-1:0] START_W  = WIDTH'(START32);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP32);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    burst_cnt_d = burst_cnt_q;
    idx_d       = idx_q;

    unique case (state_q)
      S_IDLE: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (start) begin
          state_d     = S_RUN;
          out_data_d  = START_W;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          idx_d       = '0;
        end
      end

      S_RUN: begin
        if (out_valid_q && out_ready) begin
          if (idx_q == LAST_IDX) begin
            // last word stays on out_data; only valid drops
            state_d     = S_DONE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            out_data_d = out_data_q + STEP_W;
          end
        end
      end

      S_DONE: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        burst_cnt_d = burst_cnt_q + 8'd1;
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      burst_cnt_q <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      burst_cnt_q <= burst_cnt_d;
      idx_q       <= idx_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign burst_cnt = burst_cnt_q;

endmodule
